utest_monitor: RTL and testbench

Parametrised microcode self-test checkpoint monitor. It watches the CPU's retire stream, recognises checkpoint labels (pass markers, fail traps, completion label and skip points) from a run-time loadable table, and emits timestamped events through a buffered valid/ready stream. On a skip match it issues a PC redirect request. It sits beside `cpu`/`tracer` and replaces hard-coded per-test label lists, so one block serves sectest and every later microcode test image.

---
 rtl/utest_pkg.sv | 32 +++
 rtl/utest_evq.sv | 45 ++++
 rtl/utest_monitor.sv | 187 ++++++++++++++++++
 tb/tb_utest_monitor.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/utest_pkg.sv
// rtl/utest_pkg.sv - shared types and opcode constants for the microcode self-test monitor
package utest_pkg;

    typedef enum logic [2:0] {
        K_OFF  = 3'd0,
        K_PASS = 3'd1,
        K_SKIP = 3'd2,
        K_FAIL = 3'd3,
        K_DONE = 3'd4
    } kind_t;

    typedef enum logic [2:0] {
        EV_NONE    = 3'd0,
        EV_PASS    = 3'd1,
        EV_SKIP    = 3'd2,
        EV_FAIL    = 3'd3,
        EV_DONE    = 3'd4,
        EV_TIMEOUT = 3'd5
    } ev_code_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_JUMP = 2'd2,
        S_HALT = 2'd3
    } state_t;

    // PASS markers are "continue" sequencer ops through the PE map
    localparam logic [3:0] SQI_CONT = 4'd14;
    localparam logic [1:0] MAP_PE   = 2'd0;

endpackage

// File: rtl/utest_evq.sv
// rtl/utest_evq.sv - synchronous event FIFO, accepts a push while full if a pop happens in the same cycle
module utest_evq #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty,
    output logic         drop
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/utest_monitor.sv
// rtl/utest_monitor.sv - retire-stream checkpoint monitor with loadable label table, event FIFO and skip redirect
module utest_monitor
    import utest_pkg::*;
#(
    parameter int NENT = 128,
    parameter int PCW  = 12,
    parameter int LIMW = 32,
    parameter int EVQ  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_we,
    input  logic [$clog2(NENT)-1:0] cfg_idx,
    input  logic [2:0]              cfg_kind,
    input  logic [PCW-1:0]          cfg_from,
    input  logic [PCW-1:0]          cfg_to,
    input  logic [PCW-1:0]          cfg_target,
    input  logic [LIMW-1:0]         limit,
    input  logic                    start,
    input  logic                    ret_valid,
    input  logic [PCW-1:0]          ret_pc,
    input  logic [PCW-1:0]          ret_pc_f,
    input  logic [3:0]              ret_sqi,
    input  logic [1:0]              ret_map,
    input  logic [PCW-1:0]          ret_a,
    output logic                    jump_req,
    output logic [PCW-1:0]          jump_target,
    input  logic                    jump_ack,
    output logic                    ev_valid,
    input  logic                    ev_ready,
    output logic [2:0]              ev_code,
    output logic [$clog2(NENT)-1:0] ev_idx,
    output logic [LIMW-1:0]         ev_time,
    output logic                    done,
    output logic                    fail,
    output logic                    timeout,
    output logic                    ev_ovf
);
    localparam int IW = $clog2(NENT);
    localparam int EW = 3 + IW + LIMW;

    kind_t           kind_q [NENT];
    logic [PCW-1:0]  from_q [NENT];
    logic [PCW-1:0]  to_q   [NENT];
    logic [PCW-1:0]  tgt_q  [NENT];
    logic [NENT-1:0] hit_q;

    state_t          state, state_n;
    logic [LIMW-1:0] cnt, limit_q;

    logic [NENT-1:0] m_pass, m_skip, m_fail, m_done;
    logic            matching, tmo;
    logic            push, take_pass, take_skip, set_fail, set_done, set_tmo;
    ev_code_t        push_code;
    logic [IW-1:0]   push_idx;

    logic [EW-1:0]   head;
    logic            q_full, q_empty, q_drop, pop;

    function automatic logic [IW-1:0] lowest(input logic [NENT-1:0] v);
        lowest = '0;
        for (int i = NENT - 1; i >= 0; i--) begin
            if (v[i]) lowest = IW'(i);
        end
    endfunction

    // Only the kind needs clearing: an OFF entry never matches whatever its labels hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NENT; i++) kind_q[i] <= K_OFF;
        end else if (cfg_we && state == S_IDLE) begin
            kind_q[cfg_idx] <= kind_t'(cfg_kind);
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_we && state == S_IDLE) begin
            from_q[cfg_idx] <= cfg_from;
            to_q[cfg_idx]   <= cfg_to;
            tgt_q[cfg_idx]  <= cfg_target;
        end
    end

    always_comb begin
        m_pass = '0;
        m_skip = '0;
        m_fail = '0;
        m_done = '0;
        for (int i = 0; i < NENT; i++) begin
            m_fail[i] = (kind_q[i] == K_FAIL) && (ret_pc == from_q[i]);
            m_done[i] = (kind_q[i] == K_DONE) && (ret_pc == from_q[i]);
            m_skip[i] = (kind_q[i] == K_SKIP) && (ret_pc == from_q[i]) && (ret_pc_f == to_q[i]);
            m_pass[i] = (kind_q[i] == K_PASS) && !hit_q[i] && (ret_sqi == SQI_CONT)
                        && (ret_map == MAP_PE) && (ret_a == from_q[i]);
        end
    end

    assign matching = (state == S_RUN) && ret_valid;
    assign tmo      = (limit_q != '0) && (cnt == limit_q - 1'b1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        push      = 1'b0;
        push_code = EV_NONE;
        push_idx  = '0;
        take_pass = 1'b0;
        take_skip = 1'b0;
        set_fail  = 1'b0;
        set_done  = 1'b0;
        set_tmo   = 1'b0;
        case (state)
            S_IDLE: if (start) state_n = S_RUN;
            S_RUN, S_JUMP: begin
                if (matching && |m_fail) begin
                    push = 1'b1; push_code = EV_FAIL; push_idx = lowest(m_fail);
                    set_fail = 1'b1; state_n = S_HALT;
                end else if (matching && |m_done) begin
                    push = 1'b1; push_code = EV_DONE; push_idx = lowest(m_done);
                    set_done = 1'b1; state_n = S_HALT;
                end else if (tmo) begin
                    push = 1'b1; push_code = EV_TIMEOUT;
                    set_tmo = 1'b1; state_n = S_HALT;
                end else if (matching && |m_skip) begin
                    push = 1'b1; push_code = EV_SKIP; push_idx = lowest(m_skip);
                    take_skip = 1'b1; state_n = S_JUMP;
                end else if (matching && |m_pass) begin
                    push = 1'b1; push_code = EV_PASS; push_idx = lowest(m_pass);
                    take_pass = 1'b1;
                end else if (state == S_JUMP && jump_ack) begin
                    state_n = S_RUN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            limit_q     <= '0;
            hit_q       <= '0;
            jump_target <= '0;
            done        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            ev_ovf      <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                cnt     <= '0;
                limit_q <= limit;
                hit_q   <= '0;
            end else if ((state == S_RUN || state == S_JUMP) && cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
            if (take_pass) hit_q[push_idx] <= 1'b1;
            if (take_skip) jump_target <= tgt_q[push_idx];
            if (set_fail)  fail    <= 1'b1;
            if (set_done)  done    <= 1'b1;
            if (set_tmo)   timeout <= 1'b1;
            if (q_drop)    ev_ovf  <= 1'b1;
        end
    end

    assign pop      = ev_valid && ev_ready;
    assign ev_valid = !q_empty;
    assign jump_req = (state == S_JUMP);

    utest_evq #(.DEPTH(EVQ), .W(EW)) u_evq (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({push_code, push_idx, cnt}),
        .pop       (pop),
        .head      (head),
        .full      (q_full),
        .empty     (q_empty),
        .drop      (q_drop)
    );

    assign {ev_code, ev_idx, ev_time} = ev_valid ? head : '0;

endmodule

// File: tb/tb_utest_monitor.sv
// tb/tb_utest_monitor.sv - scoreboard bench for utest_monitor against a label-table reference model
module tb_utest_monitor;
    localparam int NENT = 128, PCW = 12, LIMW = 32, EVQ = 8, IW = 7;
    localparam int MI = 0, MR = 1, MJ = 2, MH = 3;

    logic clk = 1'b0, reset = 1'b0;
    logic cfg_we = 0, start = 0, ret_valid = 0, jump_ack = 0, ev_ready = 0;
    logic [IW-1:0] cfg_idx = '0;
    logic [2:0] cfg_kind = '0;
    logic [PCW-1:0] cfg_from = '0, cfg_to = '0, cfg_target = '0;
    logic [LIMW-1:0] limit = '0;
    logic [PCW-1:0] ret_pc = '0, ret_pc_f = '0, ret_a = '0;
    logic [3:0] ret_sqi = '0;
    logic [1:0] ret_map = '0;
    logic jump_req, ev_valid, done, fail, timeout, ev_ovf;
    logic [PCW-1:0] jump_target;
    logic [2:0] ev_code;
    logic [IW-1:0] ev_idx;
    logic [LIMW-1:0] ev_time;

    always #5 clk = ~clk;

    utest_monitor #(.NENT(NENT), .PCW(PCW), .LIMW(LIMW), .EVQ(EVQ)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_kind(cfg_kind),
        .cfg_from(cfg_from), .cfg_to(cfg_to), .cfg_target(cfg_target), .limit(limit),
        .start(start), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_pc_f(ret_pc_f),
        .ret_sqi(ret_sqi), .ret_map(ret_map), .ret_a(ret_a), .jump_req(jump_req),
        .jump_target(jump_target), .jump_ack(jump_ack), .ev_valid(ev_valid),
        .ev_ready(ev_ready), .ev_code(ev_code), .ev_idx(ev_idx), .ev_time(ev_time),
        .done(done), .fail(fail), .timeout(timeout), .ev_ovf(ev_ovf)
    );

    int tests = 0, fails = 0, ev_seen = 0;

    typedef struct { int code; int idx; longint t; } ev_s;
    ev_s exq[$];

    int m_kind[NENT], m_from[NENT], m_to[NENT], m_tgt[NENT];
    bit m_hit[NENT];
    int m_state, m_occ, m_jt;
    longint m_cnt, m_lim;
    bit m_done, m_fail, m_tmo, m_ovf;

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) m_kind[i] = 0;
        m_state = MI; m_occ = 0; m_jt = 0; m_cnt = 0; m_lim = 0;
        m_done = 0; m_fail = 0; m_tmo = 0; m_ovf = 0;
        exq.delete();
    endtask

    // One clock of the checkpoint rules, evaluated on the inputs presented this cycle
    task automatic model_step();
        bit pop;
        int code, idx, f, d, s, p;
        longint t;
        if (!reset) begin model_reset(); return; end
        pop = (m_occ > 0) && ev_ready;
        code = 0; idx = 0; t = m_cnt;
        if (m_state == MI) begin
            if (cfg_we) begin
                m_kind[cfg_idx] = cfg_kind; m_from[cfg_idx] = cfg_from;
                m_to[cfg_idx] = cfg_to; m_tgt[cfg_idx] = cfg_target;
            end
            if (start) begin
                m_state = MR; m_cnt = 0; m_lim = limit;
                for (int i = 0; i < NENT; i++) m_hit[i] = 0;
            end
        end else if (m_state == MR || m_state == MJ) begin
            f = -1; d = -1; s = -1; p = -1;
            if (m_state == MR && ret_valid) begin
                for (int i = NENT - 1; i >= 0; i--) begin
                    if (m_kind[i] == 3 && ret_pc == m_from[i]) f = i;
                    if (m_kind[i] == 4 && ret_pc == m_from[i]) d = i;
                    if (m_kind[i] == 2 && ret_pc == m_from[i] && ret_pc_f == m_to[i]) s = i;
                    if (m_kind[i] == 1 && !m_hit[i] && ret_sqi == 14 && ret_map == 0 && ret_a == m_from[i]) p = i;
                end
            end
            if (f >= 0) begin code = 3; idx = f; m_fail = 1; m_state = MH; end
            else if (d >= 0) begin code = 4; idx = d; m_done = 1; m_state = MH; end
            else if (m_lim != 0 && m_cnt == m_lim - 1) begin code = 5; m_tmo = 1; m_state = MH; end
            else if (s >= 0) begin code = 2; idx = s; m_jt = m_tgt[s]; m_state = MJ; end
            else if (p >= 0) begin code = 1; idx = p; m_hit[p] = 1; end
            else if (m_state == MJ && jump_ack) m_state = MR;
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        end
        if (code != 0) begin
            if (m_occ < EVQ || pop) begin exq.push_back('{code, idx, t}); m_occ++; end
            else m_ovf = 1;
        end
        if (pop) m_occ--;
    endtask

    always @(negedge clk) begin
        logic [5:0] want, got;
        ev_s e;
        want = {m_done, m_fail, m_tmo, m_ovf, m_state == MJ, m_occ > 0};
        got  = {done, fail, timeout, ev_ovf, jump_req, ev_valid};
        tests++;
        if (got !== want || jump_target !== PCW'(m_jt)) begin
            fails++;
            $display("FAIL status @%0t: got done/fail/tmo/ovf/jreq/valid=%b tgt=%0d, want %b tgt=%0d",
                     $time, got, jump_target, want, m_jt);
        end
        if (ev_valid && ev_ready) begin
            ev_seen++;
            tests++;
            if (exq.size() == 0) begin
                fails++;
                $display("FAIL ev_unexpected @%0t: got code=%0d idx=%0d time=%0d, want no event",
                         $time, ev_code, ev_idx, ev_time);
            end else begin
                e = exq.pop_front();
                if (ev_code != 3'(e.code) || ev_idx != IW'(e.idx) || ev_time != LIMW'(e.t)) begin
                    fails++;
                    $display("FAIL ev_payload @%0t: got code=%0d idx=%0d time=%0d, want code=%0d idx=%0d time=%0d",
                             $time, ev_code, ev_idx, ev_time, e.code, e.idx, e.t);
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk); #1; model_step();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string name, input longint got, input longint want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic do_reset();
        reset = 0; model_reset();
        cfg_we = 0; start = 0; ret_valid = 0; jump_ack = 0;
        repeat (2) cyc();
        reset = 1;
        cyc();
    endtask

    task automatic wr(input int idx, input int kind, input int from, input int to, input int tgt);
        cfg_we = 1; cfg_idx = IW'(idx); cfg_kind = 3'(kind);
        cfg_from = PCW'(from); cfg_to = PCW'(to); cfg_target = PCW'(tgt);
        cyc();
        cfg_we = 0;
    endtask

    task automatic go(input int lim);
        limit = LIMW'(lim); start = 1;
        cyc();
        start = 0;
    endtask

    task automatic retire(input int pc, input int pcf, input int sqi, input int map, input int a);
        ret_valid = 1; ret_pc = PCW'(pc); ret_pc_f = PCW'(pcf);
        ret_sqi = 4'(sqi); ret_map = 2'(map); ret_a = PCW'(a);
        cyc();
        ret_valid = 0;
    endtask

    task automatic noise(input int n);
        for (int i = 0; i < n; i++) begin
            ret_valid = 1'($urandom); ret_pc = PCW'($urandom); ret_pc_f = PCW'($urandom);
            ret_sqi = 4'($urandom); ret_map = 2'($urandom); ret_a = PCW'($urandom);
            cyc();
        end
        ret_valid = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int e0;
        @(posedge clk); #1;
        do_reset();
        chk("reset_ev_valid", ev_valid, 0);
        chk("reset_jump_req", jump_req, 0);

        // PASS reports once; wrong map is ignored
        ev_ready = 1; e0 = ev_seen;
        wr(0, 1, 12, 0, 0);
        go(0);
        retire($urandom_range(200, 4000), 0, 14, 0, 12);
        retire($urandom_range(200, 4000), 0, 14, 0, 12);
        retire($urandom_range(200, 4000), 0, 14, 1, 12);
        noise(20);
        repeat (3) cyc();
        chk("pass_once", ev_seen - e0, 1);

        // SKIP redirect, retires ignored in JUMP
        do_reset(); e0 = ev_seen;
        wr(3, 2, 0, 1, 5);
        go(0);
        retire(0, 1, 0, 0, 0);
        chk("skip_jump_req", jump_req, 1);
        chk("skip_jump_target", jump_target, 5);
        for (int i = 0; i < 3; i++) retire(0, 1, 0, 0, 0);
        chk("skip_held", jump_req, 1);
        jump_ack = 1; cyc(); jump_ack = 0;
        chk("skip_ack", jump_req, 0);
        repeat (3) cyc();
        chk("skip_events", ev_seen - e0, 1);

        // FAIL beats PASS on the same retire
        do_reset(); ev_ready = 0; e0 = ev_seen;
        wr(2, 1, 1666, 0, 0);
        wr(7, 3, 1666, 0, 0);
        go(0);
        retire(1666, 0, 14, 0, 1666);
        chk("prio_code", ev_code, 3);
        chk("prio_idx", ev_idx, 7);
        chk("prio_fail", fail, 1);
        noise(10);
        ev_ready = 1; repeat (3) cyc();
        chk("prio_events", ev_seen - e0, 1);

        // Timeout at limit-1
        do_reset(); ev_ready = 0;
        go(100);
        noise(110);
        chk("tmo_flag", timeout, 1);
        chk("tmo_code", ev_code, 5);
        chk("tmo_time", ev_time, 99);
        chk("tmo_idx", ev_idx, 0);
        ev_ready = 1; repeat (3) cyc();
        do_reset();
        go(0);
        noise(10000);
        chk("no_tmo", timeout, 0);

        // Overflow with the consumer stalled, then in-order drain
        do_reset(); ev_ready = 0; e0 = ev_seen;
        for (int i = 0; i < 9; i++) wr(i, 1, 100 + i, 0, 0);
        go(0);
        for (int i = 0; i < 9; i++) retire(0, 0, 14, 0, 100 + i);
        chk("ovf_flag", ev_ovf, 1);
        ev_ready = 1; repeat (12) cyc();
        chk("ovf_drained", ev_seen - e0, 8);

        // Async reset inside JUMP clears table; writes in RUN are ignored
        do_reset();
        wr(3, 2, 0, 1, 5);
        go(0);
        retire(0, 1, 0, 0, 0);
        chk("rst_pre_jump", jump_req, 1);
        reset = 0; model_reset(); #1;
        chk("rst_jump_req", jump_req, 0);
        chk("rst_ev_valid", ev_valid, 0);
        cyc(); reset = 1; cyc();
        e0 = ev_seen;
        go(0);
        retire(0, 1, 0, 0, 0);
        chk("rst_table_clear", jump_req, 0);
        wr(5, 1, 77, 0, 0);
        retire(0, 0, 14, 0, 77);
        repeat (3) cyc();
        chk("run_cfg_ignored", ev_seen - e0, 0);

        // Random tables and traffic over a small label space
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int k = 0; k < 8; k++)
                wr($urandom_range(0, 15), $urandom_range(0, 4), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 4095));
            go(($urandom_range(0, 1) == 1) ? $urandom_range(150, 400) : 0);
            for (int i = 0; i < 300; i++) begin
                ret_valid = 1'($urandom); ret_pc = PCW'($urandom_range(0, 7));
                ret_pc_f = PCW'($urandom_range(0, 7)); ret_a = PCW'($urandom_range(0, 7));
                ret_sqi = ($urandom_range(0, 3) != 0) ? 4'd14 : 4'($urandom);
                ret_map = 2'($urandom_range(0, 1));
                ev_ready = ($urandom_range(0, 3) != 0); jump_ack = 1'($urandom);
                start = ($urandom_range(0, 15) == 0);
                cyc();
            end
            ret_valid = 0; jump_ack = 0; start = 0; ev_ready = 1;
            repeat (12) cyc();
            chk("rand_drained", exq.size(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
